// File: rtl/operand_stepper.sv
// Two-key operand stepper: synchronizes and debounces up/down push-buttons,
// then steps a wrapping 0..MAX_VAL operand with hold-to-repeat behaviour.
module operand_stepper #(
    parameter logic [15:0] DEBOUNCE      = 16'd50000,
    parameter logic [23:0] HOLD_CYCLES   = 24'd25000000,
    parameter logic [23:0] REPEAT_CYCLES = 24'd5000000,
    parameter logic [3:0]  MAX_VAL       = 4'd8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_up,
    input  logic       key_dn,
    output logic [3:0] out,
    output logic       step,
    output logic       dir
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] HOLD   = 2'd1;
    localparam logic [1:0] REPEAT = 2'd2;
    localparam logic [1:0] LOCK   = 2'd3;

    // bit 0 = up key, bit 1 = down key
    logic [1:0]  sync1;
    logic [1:0]  sync2;
    logic [1:0]  db;
    logic [1:0]  db_q;
    logic [15:0] cnt [2];

    logic [1:0]  state;
    logic [1:0]  state_n;
    logic [23:0] timer;
    logic [23:0] timer_n;
    logic        act;
    logic        act_n;
    logic        do_step;
    logic        step_up;

    logic [1:0]  rise;
    logic        act_lvl;
    logic        other_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_q  <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= {key_dn, key_up};
            sync2 <= sync1;
            db_q  <= db;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if ({1'b0, cnt[i]} + 17'd1 == {1'b0, DEBOUNCE}) begin
                    db[i]  <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 16'd1;
                end
            end
        end
    end

    assign rise       = db & ~db_q;
    assign act_lvl    = act ? db[0] : db[1];
    assign other_rise = act ? rise[1] : rise[0];

    // HOLD fires once the timer has sat at 0 (HOLD_CYCLES+1 cycles after the
    // first step); REPEAT fires on the decrement that reaches 0, giving an
    // exact REPEAT_CYCLES period.
    always_comb begin
        state_n = state;
        timer_n = timer;
        act_n   = act;
        do_step = 1'b0;
        step_up = act;
        case (state)
            IDLE: begin
                if (rise == 2'b11) begin
                    state_n = LOCK;
                end else if (rise[0] || rise[1]) begin
                    do_step = 1'b1;
                    step_up = rise[0];
                    act_n   = rise[0];
                    timer_n = HOLD_CYCLES;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (other_rise) begin
                    state_n = LOCK;
                end else if (!act_lvl) begin
                    state_n = IDLE;
                end else if (timer == '0) begin
                    do_step = 1'b1;
                    timer_n = REPEAT_CYCLES;
                    state_n = REPEAT;
                end else begin
                    timer_n = timer - 24'd1;
                end
            end
            REPEAT: begin
                if (other_rise) begin
                    state_n = LOCK;
                end else if (!act_lvl) begin
                    state_n = IDLE;
                end else if (timer <= 24'd1) begin
                    do_step = 1'b1;
                    timer_n = REPEAT_CYCLES;
                end else begin
                    timer_n = timer - 24'd1;
                end
            end
            default: begin
                if (db == 2'b00) begin
                    state_n = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
            act   <= 1'b1;
            out   <= '0;
            step  <= 1'b0;
            dir   <= 1'b1;
        end else begin
            state <= state_n;
            timer <= timer_n;
            act   <= act_n;
            step  <= do_step;
            if (do_step) begin
                dir <= step_up;
                if (step_up) begin
                    out <= (out == MAX_VAL) ? 4'd0 : out + 4'd1;
                end else begin
                    out <= (out == 4'd0) ? MAX_VAL : out - 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_operand_stepper.sv
// Directed bench for operand_stepper with a behavioural reference model
// compared every cycle, plus literal step-timing and value expectations.
module tb_operand_stepper;

    localparam int D = 4;
    localparam int H = 10;
    localparam int R = 3;
    localparam int M = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_up = 1'b0;
    logic       key_dn = 1'b0;
    logic [3:0] out;
    logic       step;
    logic       dir;

    operand_stepper #(
        .DEBOUNCE(16'(D)),
        .HOLD_CYCLES(24'(H)),
        .REPEAT_CYCLES(24'(R)),
        .MAX_VAL(4'(M))
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_up(key_up),
        .key_dn(key_dn),
        .out(out),
        .step(step),
        .dir(dir)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int steplog[$];
    bit chk_en = 1'b0;

    // Reference model: keys as edge-sampled sequences, debounced level flips
    // after D consecutive differing synchronized samples, and auto-repeat
    // expressed as the age (in edges) since the first step of a press.
    int  ms1[2], ms2[2], mdb[2], mdbp[2], mrun[2];
    int  mode;  // 0 idle, 1 one key active, 2 locked
    int  akey;
    int  age;
    int  mout;
    bit  mstep;
    bit  mdir;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        int rs[2];
        int kin[2];
        int sk;
        kin[0] = int'(key_up);
        kin[1] = int'(key_dn);
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                ms1[i] = 0; ms2[i] = 0; mdb[i] = 0; mdbp[i] = 0; mrun[i] = 0;
            end
            mode = 0; akey = 0; age = 0; mout = 0; mstep = 0; mdir = 1;
        end else begin
            for (int i = 0; i < 2; i++) rs[i] = (mdb[i] == 1 && mdbp[i] == 0) ? 1 : 0;
            mstep = 0;
            sk = -1;
            if (mode == 0) begin
                if (rs[0] == 1 && rs[1] == 1) mode = 2;
                else if (rs[0] == 1 || rs[1] == 1) begin
                    akey = (rs[0] == 1) ? 0 : 1;
                    sk = akey; age = 0; mode = 1;
                end
            end else if (mode == 1) begin
                age = age + 1;
                if (rs[1 - akey] == 1) mode = 2;
                else if (mdb[akey] == 0) mode = 0;
                else if (age == H + 1 || (age > H + 1 && (age - H - 1) % R == 0)) sk = akey;
            end else begin
                if (mdb[0] == 0 && mdb[1] == 0) mode = 0;
            end
            if (sk >= 0) begin
                mstep = 1;
                mdir = (sk == 0);
                if (sk == 0) mout = (mout == M) ? 0 : mout + 1;
                else         mout = (mout == 0) ? M : mout - 1;
            end
            for (int i = 0; i < 2; i++) begin
                mdbp[i] = mdb[i];
                if (ms2[i] == mdb[i]) mrun[i] = 0;
                else if (mrun[i] + 1 == D) begin mdb[i] = ms2[i]; mrun[i] = 0; end
                else mrun[i] = mrun[i] + 1;
                ms2[i] = ms1[i];
                ms1[i] = kin[i];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (step === 1'b1) steplog.push_back(cyc);
        if (chk_en) begin
            chk("out", 32'(out), 32'(mout));
            chk("step", 32'(step), 32'(mstep));
            chk("dir", 32'(dir), 32'(mdir));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int nsteps(input int a, input int b);
        int n = 0;
        foreach (steplog[i]) if (steplog[i] >= a && steplog[i] <= b) n++;
        return n;
    endfunction

    function automatic int nth_offset(input int p, input int k);
        int n = 0;
        foreach (steplog[i]) begin
            if (steplog[i] >= p) begin
                if (n == k) return steplog[i] - p;
                n++;
            end
        end
        return -1;
    endfunction

    task automatic press(input bit u, input bit d, input int hold, input int rel);
        key_up = u; key_dn = d;
        cycles(hold);
        key_up = 0; key_dn = 0;
        cycles(rel);
    endtask

    initial begin
        int p, q, r;
        @(negedge clk);
        chk_en = 1'b1;
        cycles(2);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_dir", 32'(dir), 32'd1);
        rst = 1'b0;
        cycles(2);

        // clean single up press
        p = cyc + 1;
        press(1, 0, 8, 12);
        chk("t030_latency", 32'(nth_offset(p, 0)), 32'd6);
        chk("t030_nsteps", 32'(nsteps(p, cyc)), 32'd1);
        chk("t030_out", 32'(out), 32'd1);
        chk("t030_dir", 32'(dir), 32'd1);

        // wrap in both directions
        press(0, 1, 8, 12);
        chk("t031_to0", 32'(out), 32'd0);
        press(0, 1, 8, 12);
        chk("t031_wrap_dn", 32'(out), 32'd8);
        chk("t031_dir", 32'(dir), 32'd0);
        press(1, 0, 8, 12);
        chk("t031_wrap_up", 32'(out), 32'd0);

        // bouncing key never steps
        p = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            key_up = 1; cycles(2);
            key_up = 0; cycles(2);
        end
        cycles(10);
        chk("t032_nsteps", 32'(nsteps(p, cyc)), 32'd0);
        chk("t032_out", 32'(out), 32'd0);
        press(1, 0, 8, 12);

        // hold into auto-repeat, then release
        p = cyc + 1;
        press(1, 0, 30, 12);
        chk("t033_off0", 32'(nth_offset(p, 0)), 32'd6);
        chk("t033_off1", 32'(nth_offset(p, 1)), 32'd17);
        chk("t033_off2", 32'(nth_offset(p, 2)), 32'd20);
        chk("t033_off3", 32'(nth_offset(p, 3)), 32'd23);
        chk("t033_nsteps", 32'(nsteps(p, cyc)), 32'd8);
        chk("t033_out", 32'(out), 32'd0);

        // second key during repeat locks out stepping
        p = cyc + 1;
        key_up = 1; cycles(20);
        q = cyc + 1;
        key_dn = 1; cycles(12);
        chk("t034_out", 32'(out), 32'd4);
        key_up = 0; cycles(12);
        key_dn = 0; cycles(12);
        chk("t034_locked", 32'(nsteps(q + 6, cyc)), 32'd0);
        chk("t034_nsteps", 32'(nsteps(p, cyc)), 32'd4);
        press(0, 1, 8, 12);
        chk("t034_after", 32'(out), 32'd3);

        // reset mid-repeat with key still held
        key_up = 1; cycles(22);
        rst = 1; cycles(1);
        r = cyc;
        chk("t035_rst_out", 32'(out), 32'd0);
        chk("t035_rst_step", 32'(step), 32'd0);
        rst = 0;
        cycles(30);
        key_up = 0; cycles(12);
        chk("t035_off0", 32'(nth_offset(r, 0)), 32'd7);
        chk("t035_off1", 32'(nth_offset(r, 1)), 32'd18);
        chk("t035_nsteps", 32'(nsteps(r, cyc)), 32'd8);
        chk("t035_out", 32'(out), 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
